sram_wait_model: RTL and testbench

//  Parametrised single-port word SRAM model for Karuta-generated designs and testbenches.

---
 rtl/sram_wait_model.sv | 105 ++++++++++
 tb/tb_sram_wait_model.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sram_wait_model.sv
// sram_wait_model: single-port word SRAM model with req/ack handshake, wait states,
// byte enables, registered read data and out-of-range error reporting.
module sram_wait_model #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 30,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                ack_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   rdata_o
);
    localparam int BE_W = DATA_W / 8;
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic                commit, sel_in, a_we, in_rng;
    logic [ADDR_W-1:0]   a_addr;
    logic [BE_W-1:0]     a_be;
    logic [DATA_W-1:0]   a_wdata;
    logic [IDX_W-1:0]    idx;

    // Storage survives reset; the initializer provides the one-time zero fill.
    logic [DATA_W-1:0]   mem_q [DEPTH] = '{default: '0};

    // With no wait states the commit edge is the accept edge, so use live inputs.
    assign sel_in  = state_q == S_IDLE;
    assign a_we    = sel_in ? we_i : we_q;
    assign a_addr  = sel_in ? addr_i : addr_q;
    assign a_be    = sel_in ? be_i : be_q;
    assign a_wdata = sel_in ? wdata_i : wdata_q;
    assign in_rng  = {1'b0, a_addr} < DEPTH_L;
    assign idx     = a_addr[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: if (req_i) begin
                state_d = WAIT_CYCLES == 0 ? S_ACK : S_WAIT;
                cnt_d   = CNT_INIT;
                commit  = WAIT_CYCLES == 0;
            end
            S_WAIT: begin
                cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
                state_d = cnt_q == 4'd0 ? S_ACK : S_WAIT;
                commit  = cnt_q == 4'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (sel_in && req_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                be_q    <= be_i;
                wdata_q <= wdata_i;
            end
            if (commit) begin
                err_q <= !in_rng;
                if (!a_we) rdata_q <= in_rng ? mem_q[idx] : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit && rst_n_i && a_we && in_rng)
            for (int k = 0; k < BE_W; k++)
                if (a_be[k]) mem_q[idx][8*k +: 8] <= a_wdata[8*k +: 8];
    end

    assign ack_o   = state_q == S_ACK;
    assign err_o   = ack_o && err_q;
    assign rdata_o = rdata_q;
endmodule

// File: tb/tb_sram_wait_model.sv
// tb_sram_wait_model: directed checks of the SRAM model with 2 wait states (dut)
// and with no wait states (dut0).
module tb_sram_wait_model;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, ack, err;
    logic [29:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0, rdata;
    logic        req0 = 1'b0, we0 = 1'b0, ack0, err0;
    logic [29:0] addr0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] wdata0 = '0, rdata0;
    int          total = 0, bad = 0;
    bit          mutate = 1'b0;
    int          lat, n_ack;
    logic        e;
    logic [31:0] rd;
    logic [5:0]  pat;

    always #5 clk = ~clk;

    sram_wait_model #(.DATA_W(32), .ADDR_W(30), .DEPTH(4096), .WAIT_CYCLES(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .ack_o(ack), .err_o(err), .rdata_o(rdata));

    sram_wait_model #(.DATA_W(32), .ADDR_W(30), .DEPTH(4096), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0), .be_i(be0),
        .wdata_i(wdata0), .ack_o(ack0), .err_o(err0), .rdata_o(rdata0));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency counts negedges after the accept edge until ack is seen.
    task automatic access(input bit w0, input logic w, input logic [29:0] a, input logic [3:0] b,
                          input logic [31:0] d, output int l, output logic er, output logic [31:0] r);
        @(negedge clk);
        if (w0) begin req0 = 1'b1; we0 = w; addr0 = a; be0 = b; wdata0 = d; end
        else begin req = 1'b1; we = w; addr = a; be = b; wdata = d; end
        l = 0;
        do begin
            @(negedge clk);
            l++;
            if (mutate && l == 1) begin addr = 30'd12; wdata = 32'h0; end
        end while (!(w0 ? ack0 : ack) && l < 20);
        er = w0 ? err0 : err;
        r = w0 ? rdata0 : rdata;
        req = 1'b0;
        req0 = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;

        access(0, 1, 30'd5, 4'hF, 32'hDEADBEEF, lat, e, rd);
        chk("t1_wr_lat", lat, 3);
        chk("t1_wr_err", e, 0);
        access(0, 0, 30'd5, 4'h0, 32'h0, lat, e, rd);
        chk("t1_rd_lat", lat, 3);
        chk("t1_rd_err", e, 0);
        chk("t1_rd_data", rd, 32'hDEADBEEF);

        access(0, 1, 30'd7, 4'hF, 32'h11223344, lat, e, rd);
        chk("t2_wr_keeps_rdata", rd, 32'hDEADBEEF);
        access(0, 1, 30'd7, 4'b0101, 32'hAABBCCDD, lat, e, rd);
        access(0, 0, 30'd7, 4'h0, 32'h0, lat, e, rd);
        chk("t2_be_merge", rd, 32'h11BB33DD);
        access(0, 1, 30'd7, 4'h0, 32'h0, lat, e, rd);
        chk("t2_be0_lat", lat, 3);
        access(0, 0, 30'd7, 4'h0, 32'h0, lat, e, rd);
        chk("t2_be0_nochange", rd, 32'h11BB33DD);

        access(0, 1, 30'd0, 4'hF, 32'h0BADF00D, lat, e, rd);
        access(0, 1, 30'd4096, 4'hF, 32'hFFFFFFFF, lat, e, rd);
        chk("t3_wr_oor_lat", lat, 3);
        chk("t3_wr_oor_err", e, 1);
        access(0, 0, 30'd4096, 4'h0, 32'h0, lat, e, rd);
        chk("t3_rd_oor_err", e, 1);
        chk("t3_rd_oor_data", rd, 0);
        @(negedge clk);
        chk("t3_err_gated", err, 0);
        access(0, 0, 30'd0, 4'h0, 32'h0, lat, e, rd);
        chk("t3_no_wrap", rd, 32'h0BADF00D);
        chk("t3_inrange_err", e, 0);

        access(1, 1, 30'd3, 4'hF, 32'h12345678, lat, e, rd);
        chk("t4_wr_lat", lat, 1);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 30'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = ack0;
            if (i == 1) chk("t4_held_mid", rdata0, 32'h12345678);
            if (i == 2) req0 = 1'b0;
        end
        chk("t4_ack_pattern", pat, 6'b000101);
        chk("t4_held_after", rdata0, 32'h12345678);

        access(0, 1, 30'd9, 4'hF, 32'h01020304, lat, e, rd);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 30'd9; be = 4'hF; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_ack_in_reset", ack, 0);
        chk("t5_rdata_reset", rdata, 0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_ack = 0;
        repeat (6) begin
            @(negedge clk);
            n_ack += int'(ack);
        end
        chk("t5_no_ack_after", n_ack, 0);
        access(0, 0, 30'd9, 4'h0, 32'h0, lat, e, rd);
        chk("t5_aborted_write", rd, 32'h01020304);

        mutate = 1'b1;
        access(0, 1, 30'd11, 4'hF, 32'hCAFEF00D, lat, e, rd);
        mutate = 1'b0;
        chk("t6_lat", lat, 3);
        access(0, 0, 30'd11, 4'h0, 32'h0, lat, e, rd);
        chk("t6_latched_addr", rd, 32'hCAFEF00D);
        access(0, 0, 30'd12, 4'h0, 32'h0, lat, e, rd);
        chk("t6_other_untouched", rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
